// File: rtl/mul.sv
// Registered signed multiplier: the full product of the two operands is clamped to the
// output range and registered once. Output is cleared asynchronously by rst.
module mul #(
  parameter int unsigned Nbits = 5,
  parameter int unsigned obits = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [Nbits:0] Delay_sig_out_b,
  input  logic [Nbits:0] out_center_der_a,
  output logic [obits:0] mul_out
);

  localparam int unsigned PW = 2 * (Nbits + 1);
  localparam int unsigned OW = obits + 1;
  // Compare width is wider than both the product and the output, so the signed limits
  // and the sign-extended product always fit.
  localparam int unsigned CW = (PW > OW) ? PW + 1 : OW + 1;

  logic signed [PW-1:0] w_prod;
  logic signed [CW-1:0] w_prod_ext;
  logic signed [CW-1:0] w_max;
  logic signed [CW-1:0] w_min;
  logic        [OW-1:0] w_sat;
  logic        [OW-1:0] r_mul_out;

  assign w_prod     = $signed(out_center_der_a) * $signed(Delay_sig_out_b);
  assign w_prod_ext = {{(CW - PW){w_prod[PW-1]}}, w_prod};
  assign w_max      = {{(CW - OW + 1){1'b0}}, {(OW - 1){1'b1}}};
  assign w_min      = {{(CW - OW + 1){1'b1}}, {(OW - 1){1'b0}}};

  always_comb begin
    w_sat = w_prod_ext[OW-1:0];
    if (w_prod_ext > w_max) begin
      w_sat = w_max[OW-1:0];
    end else if (w_prod_ext < w_min) begin
      w_sat = w_min[OW-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mul_out <= '0;
    end else begin
      r_mul_out <= w_sat;
    end
  end

  assign mul_out = r_mul_out;

endmodule

// File: tb/tb_mul.sv
// Bench for mul: directed vector table, reset sequences and random pairs on two widths
// (saturating default and a wide non-saturating configuration).
module tb_mul;

  logic       clk;
  logic       rst;
  logic [5:0] b0, a0;
  logic [5:0] out0;
  logic [3:0] b1, a1;
  logic [7:0] out1;

  int n_checks = 0;
  int n_err    = 0;

  mul #(.Nbits(5), .obits(5)) u_dut0 (
    .clk              (clk),
    .rst              (rst),
    .Delay_sig_out_b  (b0),
    .out_center_der_a (a0),
    .mul_out          (out0)
  );

  mul #(.Nbits(3), .obits(7)) u_dut1 (
    .clk              (clk),
    .rst              (rst),
    .Delay_sig_out_b  (b1),
    .out_center_der_a (a1),
    .mul_out          (out1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    int b;
    int a;
    int e;
  } vec_t;

  vec_t vecs [13];

  // Saturating product from plain integer arithmetic.
  function automatic int sat_ref(int a, int b, int ob);
    int p, mx, mn;
    p  = a * b;
    mx = (1 << ob) - 1;
    mn = -(1 << ob);
    if (p > mx) return mx;
    if (p < mn) return mn;
    return p;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int s0(input logic [5:0] v);
    return int'($signed(v));
  endfunction

  function automatic int s1(input logic [7:0] v);
    return int'($signed(v));
  endfunction

  initial begin
    int prev;
    int e0, e1;
    int ra, rb, rc, rd;

    vecs[0]  = '{b: 0,   a: 0,   e: 0};
    vecs[1]  = '{b: 1,   a: 2,   e: 2};
    vecs[2]  = '{b: 3,   a: 2,   e: 6};
    vecs[3]  = '{b: 2,   a: 2,   e: 4};
    vecs[4]  = '{b: 3,   a: 3,   e: 9};
    vecs[5]  = '{b: -1,  a: 2,   e: -2};
    vecs[6]  = '{b: -3,  a: -5,  e: 15};
    vecs[7]  = '{b: -4,  a: 8,   e: -32};
    vecs[8]  = '{b: 31,  a: 31,  e: 31};
    vecs[9]  = '{b: -32, a: 31,  e: -32};
    vecs[10] = '{b: -32, a: -32, e: 31};
    vecs[11] = '{b: 8,   a: 4,   e: 31};
    vecs[12] = '{b: -8,  a: 5,   e: -32};

    // Reset with nonzero operands: output clears at once and holds over edges.
    rst = 1'b0;
    b0 = 6'd3; a0 = 6'd3; b1 = 4'd0; a1 = 4'd0;
    #1 rst = 1'b1;
    #1 check("reset_immediate", s0(out0), 0);
    check("reset_immediate_w", s1(out1), 0);
    @(posedge clk); #1 check("reset_hold_edge1", s0(out0), 0);
    @(posedge clk); #1 check("reset_hold_edge2", s0(out0), 0);
    @(negedge clk) rst = 1'b0;
    #1 check("release_before_edge", s0(out0), 0);
    @(posedge clk); #1 check("release_first", s0(out0), 9);

    // Directed table; just before each edge the output must still hold the previous result.
    prev = 9;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      b0 = 6'(vecs[i].b);
      a0 = 6'(vecs[i].a);
      #1 check($sformatf("hold_%0d", i), s0(out0), prev);
      @(posedge clk); #1 check($sformatf("vec_%0d", i), s0(out0), vecs[i].e);
      prev = vecs[i].e;
    end

    // Mid-stream asynchronous reset, then resume with one-cycle latency.
    @(negedge clk); b0 = 6'd5; a0 = 6'd5;
    @(posedge clk); #1 check("stream_before_rst", s0(out0), 25);
    #2 rst = 1'b1;
    #1 check("midstream_rst_async", s0(out0), 0);
    @(posedge clk); #1 check("midstream_rst_hold", s0(out0), 0);
    @(negedge clk); rst = 1'b0; b0 = 6'h3e; a0 = 6'd7;
    #1 check("midstream_release_wait", s0(out0), 0);
    @(posedge clk); #1 check("midstream_resume", s0(out0), -14);

    // Random pairs on both configurations against the integer reference.
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      b0 = 6'($urandom_range(63));
      a0 = 6'($urandom_range(63));
      b1 = 4'($urandom_range(15));
      a1 = 4'($urandom_range(15));
      ra = s0(a0); rb = s0(b0);
      rc = int'($signed(a1)); rd = int'($signed(b1));
      e0 = sat_ref(ra, rb, 5);
      e1 = sat_ref(rc, rd, 7);
      @(posedge clk); #1;
      check("rand_n5_o5", s0(out0), e0);
      check("rand_n3_o7", s1(out1), e1);
    end

    // Wide configuration extremes: no clamping, sign-extended.
    @(negedge clk); b1 = 4'h8; a1 = 4'h8;
    @(posedge clk); #1 check("wide_min_min", s1(out1), 64);
    @(negedge clk); b1 = 4'h8; a1 = 4'h7;
    @(posedge clk); #1 check("wide_min_max", s1(out1), -56);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
